csr_counter: RTL and testbench

Machine counter CSR unit for the RudolV pipeline. It implements the 64-bit cycle and instructions-retired counters, and the read-only time alias, as 32-bit CSR halves. It answers the pipeline's CSR read/modify bus with a registered read response, and its read data is OR-combinable with other CSR units on the same bus.

---
 rtl/csr_counter_pkg.sv | 40 ++++
 rtl/counter64.sv | 39 +++
 rtl/csr_counter.sv | 97 +++++++++
 tb/tb_csr_counter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/csr_counter_pkg.sv
// Shared CSR definitions for the RudolV machine counter unit: addresses,
// modify encoding and the read-modify-write helper used on each 32-bit half.
package csr_counter_pkg;

  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrCycle     = 12'hC00;
  localparam logic [11:0] CsrTime      = 12'hC01;
  localparam logic [11:0] CsrInstret   = 12'hC02;
  localparam logic [11:0] CsrCycleh    = 12'hC80;
  localparam logic [11:0] CsrTimeh     = 12'hC81;
  localparam logic [11:0] CsrInstreth  = 12'hC82;

  // Codes with bit 2 set are reserved and behave like ModNone.
  typedef enum logic [2:0] {
    ModNone  = 3'b000,
    ModWrite = 3'b001,
    ModSet   = 3'b010,
    ModClear = 3'b011
  } modify_e;

  function automatic logic is_modify(logic [2:0] op);
    return (op == ModWrite) || (op == ModSet) || (op == ModClear);
  endfunction

  function automatic logic [31:0] apply_modify(logic [31:0] old_half, logic [2:0] op,
                                               logic [31:0] operand);
    logic [31:0] res;
    case (op)
      ModWrite: res = operand;
      ModSet:   res = old_half | operand;
      ModClear: res = old_half & ~operand;
      default:  res = old_half;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/counter64.sv
// 64-bit counter with increment enable and a 32-bit half modify port.
// A modify replaces the increment for the whole counter in that cycle.
module counter64
  import csr_counter_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  input  logic        mod_en,
  input  logic        mod_hi,
  input  logic [2:0]  mod_op,
  input  logic [31:0] mod_data,
  output logic [63:0] value
);

  logic [63:0] value_q, value_d;
  logic [31:0] old_half;
  logic [31:0] new_half;

  always_comb begin
    old_half = mod_hi ? value_q[63:32] : value_q[31:0];
    new_half = apply_modify(old_half, mod_op, mod_data);
    value_d  = value_q + {63'd0, inc};
    if (mod_en) begin
      value_d = mod_hi ? {new_half, value_q[31:0]} : {value_q[63:32], new_half};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value_q <= 64'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/csr_counter.sv
// Machine cycle/instret/time CSR unit: address decode, counter modify steering
// and a registered, OR-combinable read response.
module csr_counter
  import csr_counter_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        retired,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid
);

  logic [63:0] cycle_val;
  logic [63:0] instret_val;
  logic        mod_active;
  logic        cycle_mod;
  logic        instret_mod;
  logic        rd_hit;
  logic [31:0] rd_val;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;

  assign mod_active  = is_modify(modify);
  assign cycle_mod   = mod_active && ((addr == CsrMcycle) || (addr == CsrMcycleh));
  assign instret_mod = mod_active && ((addr == CsrMinstret) || (addr == CsrMinstreth));

  // Both R/W high-half addresses differ from their low halves only in bit 7.
  counter64 u_cycle (
    .clk      (clk),
    .rstn     (rstn),
    .inc      (1'b1),
    .mod_en   (cycle_mod),
    .mod_hi   (addr[7]),
    .mod_op   (modify),
    .mod_data (wdata),
    .value    (cycle_val)
  );

  counter64 u_instret (
    .clk      (clk),
    .rstn     (rstn),
    .inc      (retired),
    .mod_en   (instret_mod),
    .mod_hi   (addr[7]),
    .mod_op   (modify),
    .mod_data (wdata),
    .value    (instret_val)
  );

  always_comb begin
    rd_hit = 1'b0;
    rd_val = 32'd0;
    case (addr)
      CsrMcycle, CsrCycle, CsrTime: begin
        rd_hit = 1'b1;
        rd_val = cycle_val[31:0];
      end
      CsrMcycleh, CsrCycleh, CsrTimeh: begin
        rd_hit = 1'b1;
        rd_val = cycle_val[63:32];
      end
      CsrMinstret, CsrInstret: begin
        rd_hit = 1'b1;
        rd_val = instret_val[31:0];
      end
      CsrMinstreth, CsrInstreth: begin
        rd_hit = 1'b1;
        rd_val = instret_val[63:32];
      end
      default: ;
    endcase
  end

  // Zero data on a miss keeps the bus OR-combinable with other CSR units.
  always_comb begin
    valid_d = read && rd_hit;
    rdata_d = valid_d ? rd_val : 32'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_csr_counter.sv
// Self-checking bench for csr_counter: directed test-plan steps plus a random
// phase, all compared against a 64-bit behavioural model of both counters.
module tb_csr_counter;

  logic        clk;
  logic        rstn;
  logic        retired;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;

  int tests;
  int fails;

  longint unsigned m_cyc;
  longint unsigned m_ins;

  csr_counter dut (
    .clk     (clk),
    .rstn    (rstn),
    .retired (retired),
    .read    (read),
    .modify  (modify),
    .wdata   (wdata),
    .addr    (addr),
    .rdata   (rdata),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural view of a CSR address as the pipeline sees it.
  task automatic model_read(input logic [11:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b1;
    d   = 32'd0;
    if (a == 12'hB00 || a == 12'hC00 || a == 12'hC01)      d = m_cyc[31:0];
    else if (a == 12'hB80 || a == 12'hC80 || a == 12'hC81) d = m_cyc[63:32];
    else if (a == 12'hB02 || a == 12'hC02)                 d = m_ins[31:0];
    else if (a == 12'hB82 || a == 12'hC82)                 d = m_ins[63:32];
    else hit = 1'b0;
  endtask

  function automatic longint unsigned model_mod(longint unsigned c, logic hi, logic [2:0] op,
                                                logic [31:0] d);
    logic [31:0] h;
    logic [31:0] n;
    h = hi ? c[63:32] : c[31:0];
    if (op == 3'd1) n = d;
    else if (op == 3'd2) n = h | d;
    else n = h & ~d;
    return hi ? {n, c[31:0]} : {c[63:32], n};
  endfunction

  // One clock: predict the response from pre-edge state, advance the model,
  // then compare after the edge.
  task automatic tick();
    logic        hit;
    logic [31:0] d;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        act;
    model_read(addr, hit, d);
    exp_v = read && hit;
    exp_d = exp_v ? d : 32'd0;
    act = (modify == 3'd1) || (modify == 3'd2) || (modify == 3'd3);
    if (act && (addr == 12'hB00 || addr == 12'hB80))
      m_cyc = model_mod(m_cyc, addr == 12'hB80, modify, wdata);
    else
      m_cyc = m_cyc + 1;
    if (act && (addr == 12'hB02 || addr == 12'hB82))
      m_ins = model_mod(m_ins, addr == 12'hB82, modify, wdata);
    else if (retired)
      m_ins = m_ins + 1;
    @(posedge clk);
    #1;
    check("valid", {31'd0, valid}, {31'd0, exp_v});
    check("rdata", rdata, exp_d);
  endtask

  task automatic do_read(input logic [11:0] a);
    read   = 1'b1;
    modify = 3'd0;
    addr   = a;
    tick();
    read = 1'b0;
  endtask

  task automatic do_mod(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
    modify = op;
    addr   = a;
    wdata  = d;
    tick();
    modify = 3'd0;
  endtask

  logic [11:0] addr_list [10];

  initial begin
    tests = 0;
    fails = 0;
    addr_list = '{12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
                  12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82};
    rstn = 1'b0; retired = 1'b0; read = 1'b0; modify = 3'd0; wdata = 32'd0; addr = 12'd0;
    m_cyc = 0;
    m_ins = 0;
    #12;
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Reset count
    repeat (10) tick();
    do_read(12'hC00);
    check("reset_count", rdata, 32'd10);
    check("reset_count_valid", {31'd0, valid}, 32'd1);
    do_read(12'hC01);
    check("time_alias", rdata, 32'd11);

    // Retired count
    retired = 1'b1;
    repeat (5) tick();
    retired = 1'b0;
    do_read(12'hB02);
    check("retired_count", rdata, 32'd5);
    do_read(12'hC82);
    check("instreth_zero", rdata, 32'd0);

    // Write then read: lo wrap carries into hi
    do_mod(3'd1, 12'hB00, 32'hFFFF_FFFF);
    do_mod(3'd1, 12'hB80, 32'h0);
    tick();
    do_read(12'hB80);
    check("carry_hi", rdata, 32'd1);

    // Set and clear
    do_mod(3'd1, 12'hB02, 32'h0000_000F);
    do_mod(3'd2, 12'hB02, 32'h0000_00F0);
    do_read(12'hB02);
    check("set_bits", rdata, 32'h0000_00FF);
    do_mod(3'd3, 12'hB02, 32'h0000_000F);
    do_read(12'hB02);
    check("clear_bits", rdata, 32'h0000_00F0);

    // RO and unmapped
    do_mod(3'd1, 12'hC02, 32'h1234_5678);
    do_read(12'hC02);
    check("ro_ignored", rdata, 32'h0000_00F0);
    do_read(12'h300);
    check("unmapped_valid", {31'd0, valid}, 32'd0);
    check("unmapped_rdata", rdata, 32'd0);

    // Random traffic; reserved modify codes included
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 13);
      addr    = (r < 10) ? addr_list[r] : 12'($urandom_range(0, 4095));
      read    = 1'($urandom_range(0, 1));
      modify  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      wdata   = $urandom;
      retired = 1'($urandom_range(0, 1));
      tick();
    end
    read = 1'b0; modify = 3'd0; retired = 1'b0;

    // Reset mid-run
    do_mod(3'd1, 12'hB82, 32'hA5A5_0001);
    do_read(12'hB00);
    #3;
    rstn = 1'b0;
    #1;
    check("async_valid", {31'd0, valid}, 32'd0);
    check("async_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_cyc = 0;
    m_ins = 0;
    do_read(12'hB00);
    check("post_reset_cycle", rdata, 32'd0);
    do_read(12'hB82);
    check("post_reset_instreth", rdata, 32'd0);
    do_read(12'hB02);
    check("post_reset_instret", rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
